// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enables one oscillator, lets it settle,
// then counts synchronized rising edges of its divided output over a CLK window.
module ro_meas_ctrl #(
  parameter int N_RO       = 8,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 20,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             START,
  input  logic [SEL_W-1:0] RO_SEL,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic [N_RO-1:0]  RO_DIV,
  output logic [N_RO-1:0]  RO_EN,
  output logic             BUSY,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF,
  output logic             SEL_ERR,
  output logic             VALID,
  input  logic             READY
);

  localparam int ST_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  // An all-zero result doubles as the out-of-range indication.
  function automatic logic [N_RO-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_RO-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_RO; i++) begin
      if (sel == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Returns {overflow_attempted, next_count}; the count sticks at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    return {1'b0, c + CNT_W'(1)};
  endfunction

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] wcnt_q, wcnt_d;
  logic [ST_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sel_err_q, sel_err_d;
  logic [N_RO-1:0]  ro_en_q, ro_en_d;

  logic [N_RO-1:0]  ro_sync_p0, ro_sync_p1;
  logic             ro_prev_p2, ro_prev_d;

  logic [N_RO-1:0]  req_oh;
  logic             sync_sel;
  logic [CNT_W:0]   inc;

  // Stage p0/p1: two-flop synchronizer on every divided oscillator output
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      ro_sync_p0 <= '0;
      ro_sync_p1 <= '0;
    end else begin
      ro_sync_p0 <= RO_DIV;
      ro_sync_p1 <= ro_sync_p0;
    end
  end

  assign req_oh   = sel_onehot(RO_SEL);
  assign sync_sel = |(ro_sync_p1 & sel_onehot(sel_q));
  assign inc      = sat_inc(cnt_q);

  // Stage p2: edge-detect history and sequencer state
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      win_q      <= '0;
      wcnt_q     <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sel_err_q  <= 1'b0;
      ro_en_q    <= '0;
      ro_prev_p2 <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      win_q      <= win_d;
      wcnt_q     <= wcnt_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sel_err_q  <= sel_err_d;
      ro_en_q    <= ro_en_d;
      ro_prev_p2 <= ro_prev_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    win_d     = win_q;
    wcnt_d    = wcnt_q;
    settle_d  = settle_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sel_err_d = sel_err_q;
    ro_en_d   = ro_en_q;
    ro_prev_d = ro_prev_p2;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_SETTLE;
          sel_d     = RO_SEL;
          win_d     = WINDOW;
          settle_d  = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          sel_err_d = (req_oh == '0);
          ro_en_d   = req_oh;
        end
      end
      S_SETTLE: begin
        if (settle_q == ST_W'(SETTLE_CYC)) begin
          // Seed the history so a level already high is not counted as an edge.
          ro_prev_d = sync_sel;
          wcnt_d    = '0;
          if (win_q == '0) begin
            state_d = S_DONE;
            ro_en_d = '0;
          end else begin
            state_d = S_MEASURE;
          end
        end else begin
          settle_d = settle_q + ST_W'(1);
        end
      end
      S_MEASURE: begin
        ro_prev_d = sync_sel;
        if (sync_sel && !ro_prev_p2) begin
          cnt_d = inc[CNT_W-1:0];
          ovf_d = ovf_q | inc[CNT_W];
        end
        wcnt_d = wcnt_q + WIN_W'(1);
        if (wcnt_q == win_q - WIN_W'(1)) begin
          state_d = S_DONE;
          ro_en_d = '0;
        end
      end
      S_DONE: begin
        if (READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RO_EN   = ro_en_q;
  assign BUSY    = (state_q != S_IDLE);
  assign COUNT   = cnt_q;
  assign OVF     = ovf_q;
  assign SEL_ERR = sel_err_q;
  assign VALID   = (state_q == S_DONE);

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Bench for ro_meas_ctrl: two instances (wide and 4-bit counter) share stimulus;
// expected counts come from the recorded RO_DIV history and the 2-cycle sync latency.
module tb_ro_meas_ctrl;

  localparam int N_RO  = 8;
  localparam int SEL_W = 4;
  localparam int CNT_W = 20;
  localparam int WIN_W = 16;
  localparam int S     = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             ready = 1'b0;
  logic [SEL_W-1:0] ro_sel = '0;
  logic [WIN_W-1:0] window = '0;
  logic [N_RO-1:0]  ro_div;

  logic [N_RO-1:0]  ro_en, ro_en_s;
  logic             busy, busy_s, ovf, ovf_s, sel_err, sel_err_s, valid, valid_s;
  logic [CNT_W-1:0] count;
  logic [3:0]       count_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gcnt = 0;
  int half[N_RO] = '{default: 3};
  int phase[N_RO] = '{default: 0};
  logic [N_RO-1:0] hist [0:32767];

  ro_meas_ctrl #(.N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(S)) dut (
    .CLK(clk), .RESET_B(rst_n), .START(start), .RO_SEL(ro_sel), .WINDOW(window),
    .RO_DIV(ro_div), .RO_EN(ro_en), .BUSY(busy), .COUNT(count), .OVF(ovf),
    .SEL_ERR(sel_err), .VALID(valid), .READY(ready)
  );

  ro_meas_ctrl #(.N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(4), .WIN_W(WIN_W), .SETTLE_CYC(S)) dut_s (
    .CLK(clk), .RESET_B(rst_n), .START(start), .RO_SEL(ro_sel), .WINDOW(window),
    .RO_DIV(ro_div), .RO_EN(ro_en_s), .BUSY(busy_s), .COUNT(count_s), .OVF(ovf_s),
    .SEL_ERR(sel_err_s), .VALID(valid_s), .READY(ready)
  );

  always #5 clk = ~clk;

  // Oscillator stand-ins: square waves of period 2*half, changed just after each edge.
  initial begin : gen
    ro_div = '0;
    forever begin
      @(posedge clk);
      hist[cyc] = ro_div;
      cyc++;
      #1;
      gcnt++;
      for (int i = 0; i < N_RO; i++) ro_div[i] = (((gcnt + phase[i]) / half[i]) % 2) == 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: rising transitions of the selected line over the W sample pairs that
  // follow the settle period, shifted by the two-flop synchronizer.
  function automatic int model_count(input int k, input int sel, input int w);
    int n;
    n = 0;
    if (sel >= N_RO || w == 0) return 0;
    for (int j = 1; j <= w; j++)
      if (!hist[k+S+j-2][sel] && hist[k+S+j-1][sel]) n++;
    return n;
  endfunction

  task automatic launch(input int sel, input int w, output int k);
    ro_sel = SEL_W'(sel);
    window = WIN_W'(w);
    start  = 1'b1;
    step();
    k = cyc - 1;
    start = 1'b0;
  endtask

  // Observes both instances from edge k until VALID is due; returns mismatch tallies.
  task automatic track(input int k, input int w, input logic [N_RO-1:0] oh,
                       output int en_err, output int vld_err, output int busy_err);
    logic [N_RO-1:0] exp_en;
    en_err = 0; vld_err = 0; busy_err = 0;
    for (int e = k; e <= k + S + w + 1; e++) begin
      if (e > k) step();
      exp_en = (e < k + S + w + 1) ? oh : '0;
      if (ro_en !== exp_en || ro_en_s !== exp_en) en_err++;
      if (valid !== (e == k + S + w + 1) || valid_s !== (e == k + S + w + 1)) vld_err++;
      if (busy !== 1'b1 || busy_s !== 1'b1) busy_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({ro_en, busy, count, ovf, sel_err, valid} !== '0 ||
        {ro_en_s, busy_s, count_s, ovf_s, sel_err_s, valid_s} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ro_en=%h busy=%b count=%0d ovf=%b sel_err=%b valid=%b, all required 0",
               ro_en, busy, count, ovf, sel_err, valid);
    end
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b valid=%b required 0 0", busy, valid);
    end
  endtask

  task automatic test_nominal();
    int k, ee, ve, be;
    ready = 1'b0;
    half[2] = 2; phase[2] = $urandom_range(0, 3);
    step(); step();
    launch(2, 100, k);
    track(k, 100, 8'h04, ee, ve, be);
    checks++;
    if (ee != 0 || ve != 0 || be != 0) begin
      failures++;
      $display("FAIL nominal_timing: en_err=%0d valid_err=%0d busy_err=%0d required 0", ee, ve, be);
    end
    checks++;
    if (count !== 20'd25 || ovf !== 1'b0 || sel_err !== 1'b0) begin
      failures++;
      $display("FAIL nominal_count: count=%0d ovf=%b sel_err=%b required 25 0 0", count, ovf, sel_err);
    end
    checks++;
    if (count_s !== 4'd15 || ovf_s !== 1'b1) begin
      failures++;
      $display("FAIL nominal_narrow: count=%0d ovf=%b required 15 1", count_s, ovf_s);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nominal_handshake: valid=%b busy=%b required 0 0", valid, busy);
    end
  endtask

  task automatic test_zero_window();
    int k, ee, ve, be;
    half[0] = 1;
    step();
    launch(0, 0, k);
    track(k, 0, 8'h01, ee, ve, be);
    checks++;
    if (ee != 0 || ve != 0 || be != 0 || count !== '0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL zero_window: en_err=%0d valid_err=%0d busy_err=%0d count=%0d ovf=%b required 0s",
               ee, ve, be, count, ovf);
    end
    ready = 1'b1; step(); ready = 1'b0;
  endtask

  task automatic test_saturation();
    int k, ee, ve, be;
    half[5] = 1;
    step();
    launch(5, 64, k);
    track(k, 64, 8'h20, ee, ve, be);
    checks++;
    if (count_s !== 4'd15 || ovf_s !== 1'b1 || ee != 0 || ve != 0) begin
      failures++;
      $display("FAIL saturation: count=%0d ovf=%b en_err=%0d valid_err=%0d required 15 1 0 0",
               count_s, ovf_s, ee, ve);
    end
    checks++;
    if (count !== 20'd32 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL saturation_wide: count=%0d ovf=%b required 32 0", count, ovf);
    end
    ready = 1'b1; step(); ready = 1'b0;
  endtask

  task automatic test_bad_sel();
    int k, ee, ve, be;
    launch(9, 30, k);
    track(k, 30, 8'h00, ee, ve, be);
    checks++;
    if (sel_err !== 1'b1 || count !== '0 || count_s !== '0 || ee != 0 || ve != 0 || be != 0) begin
      failures++;
      $display("FAIL bad_sel: sel_err=%b count=%0d en_err=%0d valid_err=%0d busy_err=%0d required 1 0 0 0 0",
               sel_err, count, ee, ve, be);
    end
    ready = 1'b1; step(); ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k, k2, ee, ve, be, exp, exp2, hold_err;
    half[1] = $urandom_range(1, 4);
    step();
    launch(1, 20, k);
    track(k, 20, 8'h02, ee, ve, be);
    exp = model_count(k, 1, 20);
    checks++;
    if (count !== CNT_W'(exp) || ee != 0 || ve != 0) begin
      failures++;
      $display("FAIL b2b_first: count=%0d required %0d en_err=%0d valid_err=%0d", count, exp, ee, ve);
    end
    hold_err = 0;
    ro_sel = 4'd3; window = 16'd10;
    repeat (20) begin
      start = 1'($urandom % 2);
      step();
      if (valid !== 1'b1 || busy !== 1'b1 || count !== CNT_W'(exp) || ro_en !== '0) hold_err++;
    end
    checks++;
    if (hold_err != 0) begin
      failures++;
      $display("FAIL b2b_hold: %0d cycles disturbed, required 0", hold_err);
    end
    half[3] = 1;
    ready = 1'b1; start = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || ro_en !== '0) begin
      failures++;
      $display("FAIL b2b_idle_gap: valid=%b busy=%b ro_en=%h required 0 0 00", valid, busy, ro_en);
    end
    step();
    k2 = cyc - 1;
    start = 1'b0;
    track(k2, 10, 8'h08, ee, ve, be);
    exp2 = model_count(k2, 3, 10);
    checks++;
    if (count !== CNT_W'(exp2) || count !== 20'd5 || ee != 0 || ve != 0 || be != 0) begin
      failures++;
      $display("FAIL b2b_second: count=%0d required %0d (5) en_err=%0d valid_err=%0d busy_err=%0d",
               count, exp2, ee, ve, be);
    end
    ready = 1'b1; step(); ready = 1'b0;
  endtask

  task automatic test_random();
    int k, ee, ve, be, exp, sel, w;
    ready = 1'b1;
    for (int it = 0; it < 10; it++) begin
      sel = $urandom_range(0, 11);
      w   = $urandom_range(0, 40);
      if (sel < N_RO) begin
        half[sel]  = $urandom_range(1, 5);
        phase[sel] = $urandom_range(0, 9);
      end
      step(); step();
      launch(sel, w, k);
      track(k, w, (sel < N_RO) ? N_RO'(1 << sel) : '0, ee, ve, be);
      exp = model_count(k, sel, w);
      checks++;
      if (count !== CNT_W'(exp) || ovf !== 1'b0 || sel_err !== (sel >= N_RO) ||
          count_s !== 4'((exp > 15) ? 15 : exp) || ovf_s !== (exp > 15) ||
          ee != 0 || ve != 0 || be != 0) begin
        failures++;
        $display("FAIL random_%0d sel=%0d w=%0d: count=%0d/%0d ovf=%b/%b sel_err=%b required count=%0d en_err=%0d valid_err=%0d busy_err=%0d",
                 it, sel, w, count, count_s, ovf, ovf_s, sel_err, exp, ee, ve, be);
      end
      step();
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_handshake_%0d: valid=%b busy=%b required 0 0", it, valid, busy);
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    half[2] = 2;
    step();
    launch(2, 100, k);
    repeat (S + 30) step();
    checks++;
    if (ro_en !== 8'h04 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: ro_en=%h busy=%b required 04 1", ro_en, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ro_en !== '0 || ro_en_s !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: ro_en=%h required 00 before any edge", ro_en);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || count !== '0 || ro_en !== '0 || ovf !== 1'b0 || sel_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after: busy=%b valid=%b count=%0d ro_en=%h required 0 0 0 00",
               busy, valid, count, ro_en);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_window();
    test_saturation();
    test_bad_sel();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
- Sequencer for the standard-cell ring-oscillator characterization array on the library test chip.
- The array holds one ring oscillator per characterized cell (inv_2, nand2_1, nor2_1, buff_2, ...), each followed by an on-array divider.
- This block enables exactly one oscillator, waits for it to settle, then counts rising edges of its divided output over a programmable window of CLK cycles.
- It returns the count over a valid/ready handshake to the host register interface.

Parameters:
- N_RO, 8, number of oscillators in the array (2..16)
- SEL_W, 3, width of RO_SEL; must be >= clog2(N_RO)
- CNT_W, 20, edge counter width
- WIN_W, 16, measurement window width in CLK cycles
- SETTLE_CYC, 8, cycles between enable and start of counting; must be >= 3

Ports:
- CLK  in  1  sole clock, rising edge
- RESET_B  in  1  reset; asynchronous assert, active-low
- START  in  1  request one measurement; sampled only in IDLE
- RO_SEL  in  SEL_W  oscillator index; captured on accepted START
- WINDOW  in  WIN_W  count window in CLK cycles; captured on accepted START
- RO_DIV  in  N_RO  divided oscillator outputs; asynchronous to CLK
- RO_EN  out  N_RO  one-hot oscillator enable
- BUSY  out  1  high in every state except IDLE
- COUNT  out  CNT_W  measured edge count
- OVF  out  1  counter saturated during the window
- SEL_ERR  out  1  captured RO_SEL >= N_RO
- VALID  out  1  result available
- READY  in  1  host accepts result

Behaviour:
- Interface decision: one clock, CLK. Reset RESET_B is asynchronous and active-low.
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - captured registers, synchronizer flops, edge-detect flop and counters all 0
- Reset assertion mid-operation aborts immediately; RO_EN drops asynchronously with RESET_B.
- Synchronizer: each RO_DIV bit passes through a 2-flop synchronizer; the selected bit then feeds a rising-edge detector (prev-value flop).
- FSM states and transitions:
  - IDLE: on START=1 at edge k, capture RO_SEL and WINDOW, clear COUNT, OVF and SEL_ERR, go to SETTLE. SEL_ERR is set if the index is out of range.
  - SETTLE: RO_EN[sel]=1 from edge k onward; all zeros if SEL_ERR. Stay SETTLE_CYC cycles. On the final SETTLE cycle, load the edge-detect flop with the current synced value so no spurious edge is counted. Then go to MEASURE.
  - MEASURE: run for exactly WINDOW cycles; each detected rising edge increments COUNT. RO_EN is cleared when leaving MEASURE, then go to DONE.
  - DONE: VALID=1; COUNT, OVF and SEL_ERR are held stable. On VALID&READY, go to IDLE; VALID is 0 the next cycle.
- Latency: VALID visible after edge k+SETTLE_CYC+WINDOW+1.
- WINDOW=0: MEASURE is skipped (SETTLE goes straight to DONE), COUNT=0.
- COUNT saturates at 2^CNT_W-1 and sets OVF; it never wraps.
- START outside IDLE is ignored, including in the same cycle as the DONE handshake. START is accepted the cycle after return to IDLE if still high.
- READY outside DONE is ignored.
- SEL_ERR run completes normally with COUNT=0. No RO_EN bit is ever asserted during it.
- RO_EN is never more than one-hot; it is all zeros in IDLE and DONE.
- Count accuracy requires the RO_DIV frequency < CLK/2. Higher rates alias; the block performs no detection of this.

Test Plan:
- Reset: RESET_B low mid-MEASURE with RO_EN=8'h04 -> RO_EN=0 without a clock edge; after release, BUSY=0, VALID=0, COUNT=0.
- Nominal: SETTLE_CYC=8, RO_SEL=2, WINDOW=100, RO_DIV[2] driven with period 4 CLK, CLK-aligned -> RO_EN=8'h04 during SETTLE/MEASURE; VALID after edge k+109; COUNT=25, OVF=0.
- Zero window: WINDOW=0 with RO_DIV[0] toggling -> VALID after edge k+9, COUNT=0, RO_EN high only during SETTLE.
- Saturation: CNT_W=4, WINDOW=64, RO_DIV period 2 -> COUNT=15, OVF=1.
- Bad select: RO_SEL=9 with N_RO=8 -> SEL_ERR=1, RO_EN=0 throughout, COUNT=0, VALID asserted normally.
- Handshake/backpressure: hold READY=0 for 20 cycles in DONE while toggling START and RO_DIV -> COUNT stable, no restart. Then READY=1 with START=1 -> IDLE for one cycle, new measurement begins on the following edge.
